// File: rtl/fft_input_loader.sv
// Frame loader for the 32-point radix-2 FFT core: writes a streamed frame into
// bank 0 in bit-reversed order, then hands off to the address generation unit.
module fft_input_loader #(
  parameter int unsigned LOG2N  = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_re,
  input  logic [DATA_W-1:0]   sample_im,
  output logic                sample_ready,
  input  logic                flush,
  input  logic                fft_done,
  output logic                wr_en,
  output logic [LOG2N-1:0]    wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                start_fft,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count
);

  localparam int unsigned N = 1 << LOG2N;

  typedef enum logic [1:0] {LOAD, START, BUSY} state_t;

  state_t           state;
  logic [LOG2N-1:0] idx;
  logic [LOG2N-1:0] idx_rev;
  logic             accept;
  logic             load_wr;
  logic             last_sample;

  always_comb begin
    idx_rev = '0;
    for (int unsigned k = 0; k < LOG2N; k++) begin
      idx_rev[k] = idx[LOG2N-1-k];
    end
  end

  // Ready decodes only registered state and reset, never sample_valid.
  assign sample_ready = rst_n && (state == LOAD);
  assign busy         = (state != LOAD);
  assign accept       = sample_valid && sample_ready;
  assign load_wr      = accept && !flush;
  assign last_sample  = (idx == LOG2N'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      start_fft   <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en <= load_wr;
      if (load_wr) begin
        wr_addr <= idx_rev;
        wr_data <= {sample_re, sample_im};
      end
      case (state)
        LOAD: begin
          if (flush) begin
            idx <= '0;
          end else if (accept) begin
            idx <= idx + LOG2N'(1);
            if (last_sample) begin
              state     <= START;
              start_fft <= 1'b1;
            end
          end
        end
        // A done flag still high from the previous run must not end this one.
        START: begin
          if (!fft_done) state <= BUSY;
        end
        BUSY: begin
          if (fft_done) begin
            state       <= LOAD;
            start_fft   <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: vector table for reset/flush, then
// hand-written frame, handshake, reset and frame-counter wrap sequences.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [15:0] sample_re;
  logic [15:0] sample_im;
  logic        sample_ready;
  logic        flush;
  logic        fft_done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start_fft;
  logic        busy;
  logic [7:0]  frame_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  int unsigned addr_tab [32];

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic [15:0] re;
    logic        e_ready;
    logic        e_wr_en;
    logic [4:0]  e_addr;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  fft_input_loader #(.LOG2N(5), .DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_re(sample_re), .sample_im(sample_im), .sample_ready(sample_ready),
    .flush(flush), .fft_done(fft_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start_fft(start_fft), .busy(busy),
    .frame_count(frame_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loads n samples from idx 0 with value k = {re=k, im=~k}; n=32 completes a frame.
  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      sample_valid = 1'b1;
      sample_re    = 16'(k);
      sample_im    = ~16'(k);
      tick();
      check($sformatf("ld%0d wr_en", k), 32'(wr_en), 32'd1);
      check($sformatf("ld%0d addr", k), 32'(wr_addr), addr_tab[k]);
      check($sformatf("ld%0d data", k), wr_data, {16'(k), ~16'(k)});
      check($sformatf("ld%0d start", k), 32'(start_fft), 32'(k == 31));
      check($sformatf("ld%0d ready", k), 32'(sample_ready), 32'(k != 31));
      check($sformatf("ld%0d busy", k), 32'(busy), 32'(k == 31));
    end
    sample_valid = 1'b0;
  endtask

  // Stale done for 3 cycles, then 0, then 1 ends the run.
  task automatic run_fft(input logic hold_valid);
    sample_valid = hold_valid;
    fft_done     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stale%0d start", c), 32'(start_fft), 32'd1);
      check($sformatf("stale%0d busy", c), 32'(busy), 32'd1);
      check($sformatf("stale%0d ready", c), 32'(sample_ready), 32'd0);
      check($sformatf("stale%0d wr_en", c), 32'(wr_en), 32'd0);
    end
    fft_done = 1'b0;
    tick();
    check("run start", 32'(start_fft), 32'd1);
    check("run wr_en", 32'(wr_en), 32'd0);
    fft_done = 1'b1;
    tick();
    exp_fc = (exp_fc + 1) % 256;
    check("done start", 32'(start_fft), 32'd0);
    check("done busy", 32'(busy), 32'd0);
    check("done ready", 32'(sample_ready), 32'd1);
    check("done wr_en", 32'(wr_en), 32'd0);
    check("done fc", 32'(frame_count), 32'(exp_fc));
  endtask

  task automatic do_reset(input string tag);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    flush        = 1'b0;
    tick();
    check({tag, " wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " addr"}, 32'(wr_addr), 32'd0);
    check({tag, " data"}, wr_data, 32'd0);
    check({tag, " start"}, 32'(start_fft), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " fc"}, 32'(frame_count), 32'd0);
    check({tag, " ready"}, 32'(sample_ready), 32'd0);
    exp_fc = 0;
    rst_n  = 1'b1;
    #1;
    check({tag, " ready after"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    addr_tab = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                 1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};
    //           rst  vld  fl   re        rdy  wr   addr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'd7,   1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'd100, 1'b1, 1'b1, 5'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 1'b0, 5'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'd101, 1'b1, 1'b1, 5'd16};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'd102, 1'b1, 1'b0, 5'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'd103, 1'b1, 1'b1, 5'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'd0,   1'b1, 1'b0, 5'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'd104, 1'b1, 1'b1, 5'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'd105, 1'b1, 1'b1, 5'd16};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'd106, 1'b1, 1'b1, 5'd8};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'd0,   1'b1, 1'b0, 5'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'd107, 1'b1, 1'b1, 5'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'd0,   1'b1, 1'b0, 5'd0};

    fft_done = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rst_n        = vecs[i].rst_n;
      sample_valid = vecs[i].valid;
      flush        = vecs[i].flush;
      sample_re    = vecs[i].re;
      sample_im    = ~vecs[i].re;
      tick();
      check($sformatf("v%0d ready", i), 32'(sample_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr_en));
      check($sformatf("v%0d start", i), 32'(start_fft), 32'd0);
      check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d fc", i), 32'(frame_count), 32'd0);
      if (vecs[i].e_wr_en) begin
        check($sformatf("v%0d addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d data", i), wr_data, {vecs[i].re, ~vecs[i].re});
      end else if (!vecs[i].rst_n) begin
        check($sformatf("v%0d addr", i), 32'(wr_addr), 32'd0);
        check($sformatf("v%0d data", i), wr_data, 32'd0);
      end
    end
    flush = 1'b0;

    // Full back-to-back frame and a run with a stale done flag.
    load(32);
    run_fft(1'b0);

    // Valid toggling over 10 samples, then flush with the 11th accept.
    for (int k = 0; k < 10; k++) begin
      sample_valid = 1'b1;
      sample_re    = 16'(k);
      sample_im    = ~16'(k);
      tick();
      check($sformatf("tg%0d wr_en", k), 32'(wr_en), 32'd1);
      check($sformatf("tg%0d addr", k), 32'(wr_addr), addr_tab[k]);
      sample_valid = 1'b0;
      tick();
      check($sformatf("tg%0d idle wr_en", k), 32'(wr_en), 32'd0);
    end
    sample_valid = 1'b1;
    flush        = 1'b1;
    tick();
    check("flush drop wr_en", 32'(wr_en), 32'd0);
    flush = 1'b0;
    load(32);

    // Valid held high across the run: no writes, accept right after start drops.
    run_fft(1'b1);
    load(20);
    do_reset("rst mid-load");

    load(32);
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    tick();
    tick();
    check("busy before rst", 32'(busy), 32'd1);
    do_reset("rst mid-busy");
    load(32);
    run_fft(1'b0);
    do_reset("rst pre-wrap");

    // 256 frames wrap the 8-bit counter.
    for (int f = 0; f < 256; f++) begin
      load(32);
      fft_done = 1'b0;
      tick();
      fft_done = 1'b1;
      tick();
      exp_fc = (exp_fc + 1) % 256;
      if (f == 254 || f == 255)
        check($sformatf("wrap f%0d fc", f), 32'(frame_count), 32'(exp_fc));
    end
    check("wrap final fc", 32'(frame_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
